// File: rtl/sdram_pixel_writer.sv
// Buffers fractal_calc pixels in a small FIFO and drains them into the SDRAM
// Avalon bridge as single-word writes at the column-major display address.
module sdram_pixel_writer #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PIX_VALID,
    output logic        PIX_READY,
    input  logic [9:0]  PIX_X,
    input  logic [9:0]  PIX_Y,
    input  logic [7:0]  PIX_I,
    input  logic        FRAME_START,
    output logic [22:0] BRIDGE_ADDR,
    output logic [1:0]  BRIDGE_BYTE_EN,
    output logic        BRIDGE_WRITE,
    output logic [15:0] BRIDGE_WRITEDATA,
    input  logic        BRIDGE_ACK,
    output logic        SDRAM_DRAW,
    output logic [18:0] PIXEL_COUNT,
    output logic [7:0]  DROP_COUNT,
    output logic        FRAME_DONE
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [22:0]   STRIDE   = 23'(HEIGHT);
    localparam logic [18:0]   LAST_PIX = 19'(WIDTH * HEIGHT - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state;
    logic [30:0]   fifo_mem [DEPTH];
    logic [30:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          in_range;
    logic          accept;
    logic          push;
    logic          drop;
    logic          pop;
    logic [22:0]   pix_addr;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_range   = (32'(PIX_X) < WIDTH) && (32'(PIX_Y) < HEIGHT);
    assign accept     = PIX_VALID & PIX_READY;
    assign push       = accept & in_range;
    assign drop       = accept & ~in_range;
    assign pop        = (state == WRITE) & BRIDGE_ACK;
    assign pix_addr   = 23'(PIX_X) * STRIDE + 23'(PIX_Y);
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign head       = fifo_mem[rd_ptr];

    assign BRIDGE_BYTE_EN = 2'b11;
    assign SDRAM_DRAW     = (count != '0) || (state == WRITE);

    // Storage holds data only; validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem[wr_ptr] <= {pix_addr, PIX_I};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            PIX_READY        <= 1'b0;
            state            <= IDLE;
            BRIDGE_WRITE     <= 1'b0;
            BRIDGE_ADDR      <= '0;
            BRIDGE_WRITEDATA <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count     <= count_next;
            PIX_READY <= (count_next < FULL);

            // The head stays queued while its write is in flight; it leaves on ACK.
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        BRIDGE_ADDR      <= head[30:8];
                        BRIDGE_WRITEDATA <= {8'h00, head[7:0]};
                        BRIDGE_WRITE     <= 1'b1;
                        state            <= WRITE;
                    end
                end
                WRITE: begin
                    if (BRIDGE_ACK) begin
                        BRIDGE_WRITE <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PIXEL_COUNT <= '0;
            DROP_COUNT  <= '0;
            FRAME_DONE  <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            // A frame restart swallows a coincident ACK: it still pops but is not counted.
            if (FRAME_START) begin
                PIXEL_COUNT <= '0;
                DROP_COUNT  <= '0;
            end else begin
                if (pop) begin
                    if (PIXEL_COUNT == LAST_PIX) begin
                        PIXEL_COUNT <= '0;
                        FRAME_DONE  <= 1'b1;
                    end else begin
                        PIXEL_COUNT <= PIXEL_COUNT + 19'd1;
                    end
                end
                if (drop)
                    DROP_COUNT <= sat_inc8(DROP_COUNT);
            end
        end
    end

endmodule
